// File: rtl/sram_rd_arbiter.sv
// Two-port read arbiter for the input SRAM: same-cycle grant, registered address, tag pipe for returns.
// Define ARB_FIXED_PRIO_EN for fixed priority to port 0; default is round-robin.
module sram_rd_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              busy
);

  // Stage k holds the tag of the read granted k+1 cycles ago; the top stage is the returning word.
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_id;

`ifndef ARB_FIXED_PRIO_EN
  logic last_gnt;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
        gnt0 = 1'b1;
`else
        // Grant whichever port was not served last.
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
`endif
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sram_rd_addr <= '0;
      tag_v        <= '0;
      tag_id       <= '0;
    end else begin
      if (gnt0) begin
        sram_rd_addr <= addr0;
      end else if (gnt1) begin
        sram_rd_addr <= addr1;
      end
      tag_v  <= {tag_v[RD_LAT-2:0], gnt0 | gnt1};
      tag_id <= {tag_id[RD_LAT-2:0], gnt1};
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_gnt <= gnt1;
    end
  end
`endif

  assign rdata   = sram_rd_data;
  assign rvalid0 = !reset && tag_v[RD_LAT-1] && !tag_id[RD_LAT-1];
  assign rvalid1 = !reset && tag_v[RD_LAT-1] &&  tag_id[RD_LAT-1];
  assign busy    = !reset && (req0 || req1 || (|tag_v));

endmodule
